// File: rtl/mem_io_pkg.sv
// Shared region map, region encoding and FSM state type for the memory/IO arbiter.
package mem_io_pkg;

    localparam logic [7:0] REG_MEM = 8'h00;
    localparam logic [7:0] REG_IO1 = 8'h08;
    localparam logic [7:0] REG_IO2 = 8'h09;

    typedef enum logic [1:0] {
        RGN_NONE = 2'b00,
        RGN_MEM  = 2'b01,
        RGN_IO1  = 2'b10,
        RGN_IO2  = 2'b11
    } region_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic is_io(input region_t r);
        return (r == RGN_IO1) || (r == RGN_IO2);
    endfunction

endpackage

// File: rtl/mem_io_decode.sv
// Address-byte to region-code decoder (combinational).
module mem_io_decode
    import mem_io_pkg::*;
(
    input  logic [7:0] i_byte,
    output region_t    o_region
);

    always_comb begin
        case (i_byte)
            REG_MEM: o_region = RGN_MEM;
            REG_IO1: o_region = RGN_IO1;
            REG_IO2: o_region = RGN_IO2;
            default: o_region = RGN_NONE;
        endcase
    end

endmodule

// File: rtl/mem_io_arbiter.sv
// Two-master round-robin memory/IO bus controller with IO wait states.
// Optional per-master error flag on unmapped accesses: define MEM_IO_ERR_EN.
module mem_io_arbiter
    import mem_io_pkg::*;
#(
    parameter int IO_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        we_mem,
    output logic        we1,
    output logic        we2,
    input  logic [31:0] rd_mem,
    input  logic [31:0] rd_io1,
    input  logic [31:0] rd_io2
`ifdef MEM_IO_ERR_EN
   ,output logic        m0_err,
    output logic        m1_err
`endif
);

    localparam logic [3:0] WAIT_INIT = 4'(IO_WAIT);

    state_t      r_state, w_next;
    logic        r_gnt, r_last, r_we;
    logic [3:0]  r_cnt;
    logic [31:0] r_rdata0, r_rdata1;
    region_t     w_region;
    logic        w_any, w_gnt_id, w_zero, w_sample;
    logic [31:0] w_rd;

    assign m0_rdata = r_rdata0;
    assign m1_rdata = r_rdata1;

    // Region is always derived from the address captured at grant.
    mem_io_decode u_decode (
        .i_byte   (bus_addr[15:8]),
        .o_region (w_region)
    );

    assign w_any    = m0_req | m1_req;
    assign w_gnt_id = (m0_req & m1_req) ? ~r_last : m1_req;
    assign w_zero   = (r_cnt == 4'd0) || !is_io(w_region);

    always_comb begin
        case (w_region)
            RGN_MEM: w_rd = rd_mem;
            RGN_IO1: w_rd = rd_io1;
            RGN_IO2: w_rd = rd_io2;
            default: w_rd = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Strobes and acks decode straight from state so reset kills them at once.
    always_comb begin
        w_next   = r_state;
        w_sample = 1'b0;
        we_mem   = 1'b0;
        we1      = 1'b0;
        we2      = 1'b0;
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) w_next = ACCESS;
            end
            ACCESS: begin
                if (w_zero) begin
                    w_next   = DONE;
                    w_sample = 1'b1;
                    we_mem   = r_we && (w_region == RGN_MEM);
                    we1      = r_we && (w_region == RGN_IO1);
                    we2      = r_we && (w_region == RGN_IO2);
                end
            end
            DONE: begin
                w_next = IDLE;
                m0_ack = ~r_gnt;
                m1_ack = r_gnt;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt     <= 1'b0;
            r_last    <= 1'b1;
            r_we      <= 1'b0;
            r_cnt     <= 4'd0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            r_rdata0  <= 32'h0;
            r_rdata1  <= 32'h0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_gnt     <= w_gnt_id;
                r_last    <= w_gnt_id;
                r_we      <= w_gnt_id ? m1_we    : m0_we;
                bus_addr  <= w_gnt_id ? m1_addr  : m0_addr;
                bus_wdata <= w_gnt_id ? m1_wdata : m0_wdata;
                r_cnt     <= WAIT_INIT;
            end else if (r_state == ACCESS && !w_zero) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_sample) begin
                if (r_gnt) r_rdata1 <= w_rd;
                else       r_rdata0 <= w_rd;
            end
        end
    end

`ifdef MEM_IO_ERR_EN
    assign m0_err = (r_state == DONE) && !r_gnt && (w_region == RGN_NONE);
    assign m1_err = (r_state == DONE) &&  r_gnt && (w_region == RGN_NONE);
`endif

endmodule

// File: tb/tb_mem_io_arbiter.sv
// Bench for mem_io_arbiter: directed scenarios plus randomized two-master traffic
// checked every cycle against a transaction-timeline model.
module tb_mem_io_arbiter;

    localparam int TB_WAIT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic [31:0] rd_mem = '0, rd_io1 = '0, rd_io2 = '0;
    logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
    logic        m0_ack, m1_ack, we_mem, we1, we2;
`ifdef MEM_IO_ERR_EN
    logic        m0_err, m1_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    mem_io_arbiter #(.IO_WAIT(TB_WAIT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .we_mem(we_mem), .we1(we1), .we2(we2),
        .rd_mem(rd_mem), .rd_io1(rd_io1), .rd_io2(rd_io2)
`ifdef MEM_IO_ERR_EN
       ,.m0_err(m0_err), .m1_err(m1_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // 0 unmapped, 1 memory, 2 IO1, 3 IO2
    function automatic int rgn(input logic [31:0] a);
        if (a[15:8] == 8'h00) return 1;
        if (a[15:8] == 8'h08) return 2;
        if (a[15:8] == 8'h09) return 3;
        return 0;
    endfunction

    // Timeline model: a grant in cycle k acks in cycle k+2(+wait for IO); the
    // access (strobe, read capture) happens the cycle before the ack.
    logic        md_busy = 1'b0, md_cur = 1'b0, md_we = 1'b0, md_last = 1'b1;
    logic [31:0] md_addr = '0, md_bus_a = '0, md_bus_d = '0;
    logic [31:0] md_rd0 = '0, md_rd1 = '0;
    int          md_k = 0, md_done = 0;

    always @(negedge clk) begin
        logic e_a0, e_a1, e_wm, e_w1, e_w2, stb, g;
        int   r;
        md_k++;
        if (rst) begin
            md_busy = 1'b0; md_last = 1'b1;
            md_rd0 = '0; md_rd1 = '0; md_bus_a = '0; md_bus_d = '0;
        end
        r    = rgn(md_addr);
        stb  = !rst && md_busy && (md_k == md_done - 1);
        e_a0 = !rst && md_busy && (md_k == md_done) && !md_cur;
        e_a1 = !rst && md_busy && (md_k == md_done) &&  md_cur;
        e_wm = stb && md_we && (r == 1);
        e_w1 = stb && md_we && (r == 2);
        e_w2 = stb && md_we && (r == 3);
        chk("m0_ack", 32'(m0_ack), 32'(e_a0));
        chk("m1_ack", 32'(m1_ack), 32'(e_a1));
        chk("we_mem", 32'(we_mem), 32'(e_wm));
        chk("we1", 32'(we1), 32'(e_w1));
        chk("we2", 32'(we2), 32'(e_w2));
        chk("m0_rdata", m0_rdata, md_rd0);
        chk("m1_rdata", m1_rdata, md_rd1);
        chk("bus_addr", bus_addr, md_bus_a);
        chk("bus_wdata", bus_wdata, md_bus_d);
`ifdef MEM_IO_ERR_EN
        chk("m0_err", 32'(m0_err), 32'(e_a0 && r == 0));
        chk("m1_err", 32'(m1_err), 32'(e_a1 && r == 0));
`endif
        if (!rst) begin
            if (stb) begin
                logic [31:0] v;
                v = (r == 1) ? rd_mem : (r == 2) ? rd_io1 : (r == 3) ? rd_io2 : 32'h0;
                if (md_cur) md_rd1 = v; else md_rd0 = v;
            end
            if (md_busy && md_k == md_done) begin
                md_busy = 1'b0;
            end else if (!md_busy && (m0_req || m1_req)) begin
                g = (m0_req && m1_req) ? !md_last : m1_req;
                md_last  = g;
                md_cur   = g;
                md_busy  = 1'b1;
                md_we    = g ? m1_we : m0_we;
                md_addr  = g ? m1_addr : m0_addr;
                md_bus_a = md_addr;
                md_bus_d = g ? m1_wdata : m0_wdata;
                md_done  = md_k + 2 + ((rgn(md_addr) >= 2) ? TB_WAIT : 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic rq, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin m0_req = rq; m0_we = we; m0_addr = a; m0_wdata = d; end
        else        begin m1_req = rq; m1_we = we; m1_addr = a; m1_wdata = d; end
    endtask

    int          lat, s_wm, s_w1, s_w2, s_err;
    logic [31:0] s_wd;

    // Issue one transaction from an IDLE cycle and follow it to its ack.
    task automatic txn(input int m, input logic we, input logic [31:0] a, input logic [31:0] d);
        logic ak;
        set_m(m, 1'b1, we, a, d);
        lat = 0; s_wm = 0; s_w1 = 0; s_w2 = 0; s_err = 0; s_wd = '0;
        do begin
            tick();
            lat++;
            if (we_mem) s_wm++;
            if (we1) s_w1++;
            if (we2) begin s_w2++; s_wd = bus_wdata; end
`ifdef MEM_IO_ERR_EN
            if ((m == 0) ? m0_err : m1_err) s_err++;
`endif
            ak = (m == 0) ? m0_ack : m1_ack;
        end while (!ak && lat < 40);
        if (!ak) begin
            n_cmp++; n_bad++;
            $display("FAIL ack_timeout m%0d: no ack within %0d cycles", m, lat);
        end
        set_m(m, 1'b0, 1'b0, a, d);
    endtask

    task automatic new_req(input int m);
        logic [7:0] b;
        case ($urandom_range(3, 0))
            0: b = 8'h00;
            1: b = 8'h08;
            2: b = 8'h09;
            default: b = 8'($urandom);
        endcase
        set_m(m, 1'b1, 1'($urandom), {16'($urandom), b, 8'($urandom)}, $urandom);
    endtask

    initial begin
        int cnt;
        int gap0, gap1, wt0, wt1;
        repeat (3) tick();
        chk("rst_m0_ack", 32'(m0_ack), 32'd0);
        chk("rst_strobes", {29'd0, we_mem, we1, we2}, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
`ifdef MEM_IO_ERR_EN
        chk("rst_err", {30'd0, m0_err, m1_err}, 32'd0);
`endif
        rst = 1'b0;
        rd_mem = 32'hDEAD_BEEF; rd_io1 = 32'h1111_1111; rd_io2 = 32'h2222_2222;

        tick();
        txn(0, 1'b0, 32'h0000_0010, 32'h0);
        chk("mem_rd_latency", 32'(lat), 32'd2);
        chk("mem_rd_data", m0_rdata, 32'hDEAD_BEEF);

        tick();
        txn(0, 1'b1, 32'h0000_0500, 32'hA5A5_A5A5);
        chk("unmapped_wr_latency", 32'(lat), 32'd2);
        chk("unmapped_wr_strobes", 32'(s_wm + s_w1 + s_w2), 32'd0);
`ifdef MEM_IO_ERR_EN
        chk("unmapped_wr_err", 32'(s_err), 32'd1);
`endif
        tick();
        txn(0, 1'b0, 32'h0000_0500, 32'h0);
        chk("unmapped_rd_data", m0_rdata, 32'h0);

        tick();
        txn(1, 1'b1, 32'h0000_0900, 32'h55);
        chk("io2_wr_latency", 32'(lat), 32'd4);
        chk("io2_we2_cycles", 32'(s_w2), 32'd1);
        chk("io2_wdata", s_wd, 32'h55);
        chk("io2_other_strobes", 32'(s_wm + s_w1), 32'd0);
`ifdef MEM_IO_ERR_EN
        chk("io2_err", 32'(s_err), 32'd0);
`endif

        // Both masters hammer memory: m0 acks at 2 and 8, m1 at 5 and 11.
        tick();
        set_m(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
        set_m(1, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        for (int i = 1; i <= 11; i++) begin
            tick();
            chk($sformatf("rr_m0_ack_c%0d", i), 32'(m0_ack), 32'(i == 2 || i == 8));
            chk($sformatf("rr_m1_ack_c%0d", i), 32'(m1_ack), 32'(i == 5 || i == 11));
        end
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // IO1 write from m0 (makes m0 'last'), reset in its second wait cycle.
        tick();
        set_m(0, 1'b1, 1'b1, 32'h0000_0800, 32'h77);
        tick();
        tick();
        rst = 1'b1;
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("rst_mid_immediate", {29'd0, m0_ack, m1_ack, we1}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            cnt += int'(we1) + int'(m0_ack) + int'(m1_ack);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            cnt += int'(we1) + int'(m0_ack) + int'(m1_ack);
        end
        chk("rst_mid_no_pulses", 32'(cnt), 32'd0);
        set_m(0, 1'b1, 1'b0, 32'h0000_0030, 32'h0);
        set_m(1, 1'b1, 1'b0, 32'h0000_0034, 32'h0);
        lat = 0;
        do begin tick(); lat++; end while (!(m0_ack || m1_ack) && lat < 40);
        chk("post_rst_tie_lat", 32'(lat), 32'd2);
        chk("post_rst_tie_winner", {30'd0, m0_ack, m1_ack}, 32'b10);
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        lat = 0;
        do begin tick(); lat++; end while (!m1_ack && lat < 40);
        chk("post_rst_m1_served", 32'(lat), 32'd3);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Randomized traffic; the model checks every cycle.
        gap0 = 0; gap1 = 0; wt0 = 0; wt1 = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            rd_mem = $urandom; rd_io1 = $urandom; rd_io2 = $urandom;
            if (m0_req && m0_ack) begin
                wt0 = 0;
                if ($urandom_range(1, 0) == 1) new_req(0);
                else begin m0_req = 1'b0; gap0 = $urandom_range(3, 0); end
            end else if (m0_req) begin
                wt0++;
                if (wt0 == 40) begin
                    n_cmp++; n_bad++;
                    $display("FAIL starve_m0: waited %0d cycles, required < 40", wt0);
                end
            end else if (gap0 == 0) new_req(0);
            else gap0--;
            if (m1_req && m1_ack) begin
                wt1 = 0;
                if ($urandom_range(1, 0) == 1) new_req(1);
                else begin m1_req = 1'b0; gap1 = $urandom_range(3, 0); end
            end else if (m1_req) begin
                wt1++;
                if (wt1 == 40) begin
                    n_cmp++; n_bad++;
                    $display("FAIL starve_m1: waited %0d cycles, required < 40", wt1);
                end
            end else if (gap1 == 0) new_req(1);
            else gap1--;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/mem_io_arbiter.md
# mem_io_arbiter

Two-master controller for the MIPS memory/IO bus: arbitrates between the CPU data port (master 0) and a DMA/debug port (master 1), decodes the granted address into the data-memory, IO port 1 or IO port 2 region, and sequences each access. Memory accesses complete in a fixed single access cycle; IO accesses get parameterised wait states. It sits between the core's data interface and the data memory and IO registers, replacing direct CPU wiring of the write strobes and read-data mux.

## Interface
- `IO_WAIT`, default 2: extra access cycles for IO regions (0..15).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `m0_req`, `m1_req` in 1: master request; held high with address and data stable until ack.
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr` in 32: byte address; region selected by bits [15:8].
- `m0_wdata`, `m1_wdata` in 32: write data.
- `m0_rdata`, `m1_rdata` out 32: read data, valid in the ack cycle; holds its value until the next ack to that master.
- `m0_ack`, `m1_ack` out 1: one-cycle completion pulse.
- `bus_addr` out 32, `bus_wdata` out 32: granted master's address and data, registered at grant.
- `we_mem`, `we1`, `we2` out 1: write strobes for data memory, IO1 and IO2.
- `rd_mem`, `rd_io1`, `rd_io2` in 32: region read data.
- `m0_err`, `m1_err` out 1: present only with `MEM_IO_ERR_EN`.

## Operation
- Region map on `addr[15:8]`: 8'h00 is memory, 8'h08 is IO1, 8'h09 is IO2, all other values are unmapped.
- FSM states:
  - IDLE: arbitrate among asserted requests. On a grant, latch the master id, `we`, `addr`, `wdata` and region; go to ACCESS.
  - ACCESS: the wait counter loads 0 for memory and unmapped, `IO_WAIT` for IO. While the counter is nonzero it decrements. At zero the FSM samples read data into the master's rdata register, asserts the region's write strobe for that single cycle (writes only, never for unmapped), then goes to DONE.
  - DONE: assert the granted master's ack for one cycle; go to IDLE.
- Arbitration is round-robin using the `last` bit, which records the last granted master.
  - If only one master requests, it is granted.
  - If both request, the master other than `last` is granted.
  - `last` resets to 1, so master 0 wins the first tie.
- Read mux selects `rd_mem`, `rd_io1` or `rd_io2` by the latched region. Unmapped reads return 32'h0; unmapped writes are dropped.
- At most one write strobe is ever high; strobes are never high outside ACCESS.

## Timing
- Reset values: FSM = IDLE, `last` = 1, all acks, strobes and err = 0, `bus_addr`/`bus_wdata`/rdata registers = 0.
- Latency from the request sampled in IDLE to ack:
  - memory or unmapped: 2 cycles;
  - IO: 2 + `IO_WAIT` cycles.
- Back-to-back throughput: one transaction per 3 cycles for memory. A request held high through its ack cycle is treated as a new request in the following IDLE cycle.
- A request that arrives while the FSM is busy waits; no request is lost.
- Dropping `req` before ack is a protocol violation. The transaction completes anyway and the ack is still issued.
- `rst` asserted mid-transaction clears strobes and acks immediately (asynchronously). The in-flight access is abandoned with no write strobe and no ack.

## Configuration
- `MEM_IO_ERR_EN` defined:
  - `m0_err`/`m1_err` exist.
  - The granted master's err is asserted together with its ack when the region is unmapped.
  - err is 0 for every other transaction.
- `MEM_IO_ERR_EN` undefined: no err ports; unmapped accesses complete silently with ack, as described in Operation.

## Structure
- Package `mem_io_pkg`:
  - region byte constants `REG_MEM` = 8'h00, `REG_IO1` = 8'h08, `REG_IO2` = 8'h09;
  - 2-bit region encoding: 00 unmapped, 01 mem, 10 IO1, 11 IO2;
  - FSM state enum IDLE/ACCESS/DONE.
- Sub-module `mem_io_decode`, purely combinational: address byte in, 2-bit region code out. It is used once, on the latched address.

## Test plan
- Reset state: assert `rst`; all acks, strobes and err are 0, FSM is IDLE. Release `rst`, then assert `m0_req` read at 32'h0000_0010 with `rd_mem` = 32'hDEAD_BEEF. `m0_ack` pulses 2 cycles later with `m0_rdata` = 32'hDEAD_BEEF.
- IO write wait states: with `IO_WAIT` = 2, `m1` writes 32'h55 to 32'h0000_0900. `we2` is high for exactly one cycle with `bus_wdata` = 32'h55, `m1_ack` pulses 4 cycles after the request, and `we_mem`/`we1` stay 0.
- Round-robin fairness: both masters request continuously. Grants alternate m0, m1, m0, m1, with each master acked every 6 cycles for memory accesses.
- Unmapped access: `m0` writes to 32'h0000_0500. No write strobe fires, `m0_ack` pulses after 2 cycles, and a read from the same address returns 0. With `MEM_IO_ERR_EN`, `m0_err` = 1 in the ack cycle.
- Reset mid-operation: assert `rst` during the second wait cycle of an IO1 write. `we1` never pulses, there is no ack, and after reset release the next tie is granted to m0.
